hilo_muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide engine with architectural HI/LO registers for the CPU execute stage.
- Consumes a registered operation code from the control path (mult/div/mthi/mtlo class) and produces HI/LO values.
- Drives a stall request that freezes the pipeline while an operation is in flight.
- Supports signed and unsigned multiply and divide, with a configurable datapath width and multiply latency.

---
 rtl/hilo_muldiv_if.sv | 27 ++
 rtl/hilo_muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_if.sv
// Request/result bundle between the execute stage and the HI/LO multiply/divide unit.
interface hilo_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             stall;

  // Control path side: issues operations, observes HI/LO and the stall.
  modport master (
    output start, op, a, b, flush,
    input  hi, lo, busy, done, stall
  );

  // Unit side.
  modport slave (
    input  start, op, a, b, flush,
    output hi, lo, busy, done, stall
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide engine owning the architectural HI/LO registers.
// Multiply is a fixed-latency single product; divide is a radix-2 restoring
// divider on operand magnitudes with signs fixed up on the final step.
module hilo_muldiv_unit #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 2,
  parameter bit          DIV0_KEEP  = 1'b1
) (
  input logic         clk,
  input logic         resetn,
  hilo_muldiv_if.slave bus
);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  localparam int unsigned CntMax = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic [WIDTH-1:0]  opa_q, opa_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic              sgn_q, sgn_d;
  logic              div0_q, div0_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic              accept;
  logic              mdu_op;
  logic              in_sgn;
  logic [WIDTH-1:0]  a_mag_in;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic [WIDTH-1:0]  div_mag;
  logic [WIDTH:0]    div_shift, div_diff;
  logic [WIDTH-1:0]  quo_nx, rem_nx;
  logic              quo_neg, rem_neg;
  logic [WIDTH-1:0]  quo_res, rem_res;

  assign accept = bus.start && !bus.flush && (state_q == StIdle || state_q == StDone);
  assign mdu_op = (bus.op >= OpMult) && (bus.op <= OpDivu);
  assign in_sgn = (bus.op == OpMult) || (bus.op == OpDiv);

  // Datapath helpers: magnitudes, product and one restoring-divide step.
  always_comb begin
    a_mag_in  = (in_sgn && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    ext_a     = {{WIDTH{sgn_q & opa_q[WIDTH-1]}}, opa_q};
    ext_b     = {{WIDTH{sgn_q & opb_q[WIDTH-1]}}, opb_q};
    prod      = ext_a * ext_b;
    div_mag   = (sgn_q && opb_q[WIDTH-1]) ? (~opb_q + 1'b1) : opb_q;
    div_shift = {rem_q, quo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, div_mag};
    quo_nx    = {quo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    rem_nx    = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
    quo_neg   = sgn_q & (opa_q[WIDTH-1] ^ opb_q[WIDTH-1]);
    rem_neg   = sgn_q & opa_q[WIDTH-1];
    quo_res   = quo_neg ? (~quo_nx + 1'b1) : quo_nx;
    rem_res   = rem_neg ? (~rem_nx + 1'b1) : rem_nx;
  end

  // Next-state and HI/LO write decisions.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    sgn_d   = sgn_q;
    div0_d  = div0_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (accept) begin
          case (bus.op)
            OpMult, OpMultu: begin
              opa_d   = bus.a;
              opb_d   = bus.b;
              sgn_d   = in_sgn;
              cnt_d   = '0;
              state_d = StMul;
            end
            OpDiv, OpDivu: begin
              opa_d   = bus.a;
              opb_d   = bus.b;
              sgn_d   = in_sgn;
              div0_d  = (bus.b == '0);
              quo_d   = a_mag_in;
              rem_d   = '0;
              cnt_d   = '0;
              state_d = StDiv;
            end
            OpMthi:  hi_d = bus.a;
            OpMtlo:  lo_d = bus.a;
            default: ;
          endcase
        end
      end
      StMul: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else if (cnt_q == CntW'(MUL_CYCLES - 1)) begin
          {hi_d, lo_d} = prod;
          state_d      = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDiv: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else if (div0_q) begin
          if (!DIV0_KEEP) begin
            hi_d = opa_q;
            lo_d = '1;
          end
          state_d = StDone;
        end else begin
          quo_d = quo_nx;
          rem_d = rem_nx;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            lo_d    = quo_res;
            hi_d    = rem_res;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      sgn_q   <= 1'b0;
      div0_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      sgn_q   <= sgn_d;
      div0_q  <= div0_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = (state_q == StMul) || (state_q == StDiv);
  assign bus.done  = (state_q == StDone);
  assign bus.stall = bus.busy || (accept && mdu_op);

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit with hand-computed expected values.
module tb_hilo_muldiv_unit;

  localparam logic [2:0] OpNop   = 3'd0;
  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;
  localparam logic [2:0] OpRsvd  = 3'd7;

  logic clk;
  logic resetn;
  int   n_cmp;
  int   n_err;

  hilo_muldiv_if #(.WIDTH(32)) bus ();

  hilo_muldiv_unit #(
    .WIDTH      (32),
    .MUL_CYCLES (2),
    .DIV0_KEEP  (1'b1)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a request for one cycle starting at the current falling edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic exp_stall);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    #1;
    check("stall_on_issue", bus.stall, exp_stall);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = OpNop;
  endtask

  // Count busy cycles until done, bounded.
  task automatic wait_done(input string tag, input int exp_cycles);
    int cycles;
    cycles = 0;
    while (bus.busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, cycles, exp_cycles);
    check({tag, "_done"}, bus.done, 1'b1);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    resetn    = 1'b0;
    bus.start = 1'b0;
    bus.op    = OpNop;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_stall", bus.stall, 0);
    resetn = 1'b1;
    @(negedge clk);

    // Moves to HI/LO.
    issue(OpMthi, 32'h1234_5678, 32'h0, 1'b0);
    check("mthi_hi", bus.hi, 32'h1234_5678);
    check("mthi_busy", bus.busy, 0);
    check("mthi_done", bus.done, 0);
    issue(OpMtlo, 32'hCAFE_BABE, 32'h0, 1'b0);
    check("mtlo_lo", bus.lo, 32'hCAFE_BABE);
    check("mtlo_hi", bus.hi, 32'h1234_5678);
    check("mtlo_done", bus.done, 0);
    check("mtlo_stall", bus.stall, 0);

    // Reserved op and flushed MTHI have no effect.
    issue(OpRsvd, 32'h5555_5555, 32'h1, 1'b0);
    check("rsvd_hi", bus.hi, 32'h1234_5678);
    check("rsvd_busy", bus.busy, 0);
    bus.flush = 1'b1;
    issue(OpMthi, 32'h1111_1111, 32'h0, 1'b0);
    bus.flush = 1'b0;
    check("flush_mthi_hi", bus.hi, 32'h1234_5678);

    // Multiplies.
    issue(OpMult, 32'hFFFF_FFFE, 32'd3, 1'b1);
    wait_done("mult", 2);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFFA);
    @(negedge clk);
    check("mult_done_pulse", bus.done, 0);
    issue(OpMultu, 32'hFFFF_FFFE, 32'd3, 1'b1);
    wait_done("multu", 2);
    check("multu_hi", bus.hi, 32'h0000_0002);
    check("multu_lo", bus.lo, 32'hFFFF_FFFA);
    @(negedge clk);

    // Divides.
    issue(OpDiv, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done("div", 32);
    check("div_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_hi", bus.hi, 32'hFFFF_FFFF);
    @(negedge clk);
    issue(OpDivu, 32'd100, 32'd7, 1'b1);
    wait_done("divu", 32);
    check("divu_lo", bus.lo, 32'd14);
    check("divu_hi", bus.hi, 32'd2);
    @(negedge clk);
    issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done("div_minneg", 32);
    check("div_minneg_lo", bus.lo, 32'h8000_0000);
    check("div_minneg_hi", bus.hi, 32'h0);
    @(negedge clk);
    issue(OpDivu, 32'd55, 32'd0, 1'b1);
    wait_done("div0", 1);
    check("div0_lo", bus.lo, 32'h8000_0000);
    check("div0_hi", bus.hi, 32'h0);
    @(negedge clk);

    // Flush at busy cycle 10; a start at busy cycle 5 is ignored.
    issue(OpDiv, 32'd50, 32'd3, 1'b1);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OpMthi;
    bus.a     = 32'hDEAD_BEEF;
    #1;
    check("busy_start_stall", bus.stall, 1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = OpNop;
    check("busy_start_ignored_hi", bus.hi, 32'h0);
    check("busy_start_still_busy", bus.busy, 1);
    repeat (4) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", bus.busy, 0);
    check("flush_done", bus.done, 0);
    check("flush_hi", bus.hi, 32'h0);
    check("flush_lo", bus.lo, 32'h8000_0000);
    @(negedge clk);
    check("flush_no_late_done", bus.done, 0);

    // Back-to-back: MULTU accepted in the DONE cycle of a DIVU.
    issue(OpDivu, 32'd100, 32'd7, 1'b1);
    wait_done("b2b_divu", 32);
    check("b2b_divu_lo", bus.lo, 32'd14);
    issue(OpMultu, 32'd5, 32'd6, 1'b1);
    check("b2b_done_drop", bus.done, 0);
    check("b2b_busy", bus.busy, 1);
    wait_done("b2b_multu", 2);
    check("b2b_multu_lo", bus.lo, 32'd30);
    check("b2b_multu_hi", bus.hi, 32'd0);
    @(negedge clk);
    check("b2b_done_once", bus.done, 0);

    // Reset during MUL.
    issue(OpMult, 32'd7, 32'd9, 1'b1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("mulrst_hi", bus.hi, 0);
    check("mulrst_lo", bus.lo, 0);
    check("mulrst_busy", bus.busy, 0);
    check("mulrst_done", bus.done, 0);
    repeat (3) @(negedge clk);
    check("mulrst_no_write", bus.lo, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
